// File: rtl/display_scanner.sv
// display_scanner
//   Time-multiplexed driver for a bank of common-anode 7-segment digits.
//   Each digit owns a slot of CLK_DIV cycles. The first BLANK_CYCLES of a
//   slot keep every anode off (anti-ghosting). The rest of the slot drives
//   the digit's anode with the segment pattern captured at the moment the
//   slot entered its drive phase.
//
// Ports
//   clk          : single clock, all state on the rising edge
//   rst          : synchronous, active-high reset
//   segments_in  : NUM_DIGITS*7 bits, active-low patterns, digit i in [7i+6:7i]
//   digit_en     : NUM_DIGITS bits, 1 = digit is shown
//   seg_out      : 7 bits, active-low segment drive (registered)
//   an_out       : NUM_DIGITS bits, active-low anodes, at most one low (registered)
//   digit_idx    : current slot digit index (registered)
//   frame_done   : one-cycle pulse when the scan returns to digit 0 (registered)
module display_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS*7-1:0]       segments_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  output logic [6:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Control state
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  state_t                r_state;

  // Registered outputs
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame;

  // Per-slot snapshot of the digit being shown
  logic [6:0]            r_snap_seg;
  logic                  r_snap_en;

  // Next-state / next-output signals
  logic                  w_slot_wrap;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  int                    w_cnt_int;
  state_t                w_state_nxt;
  logic                  w_enter;
  logic [6:0]            w_in_seg;
  logic                  w_in_en;
  logic [6:0]            w_cur_seg;
  logic                  w_cur_en;
  logic [6:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic                  w_frame_nxt;

  // Slot counter and digit index advance; idx moves on the same edge cnt wraps.
  always_comb begin
    w_slot_wrap = (r_cnt == CNT_LAST);
    w_cnt_nxt   = w_slot_wrap ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    if (w_slot_wrap) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end
    w_frame_nxt = w_slot_wrap && (r_idx == IDX_LAST);
  end

  // Input mux selecting the digit addressed by the post-edge index.
  always_comb begin
    w_in_seg = segments_in[6:0];
    w_in_en  = digit_en[0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_in_seg = segments_in[7*i +: 7];
        w_in_en  = digit_en[i];
      end
    end
  end

  // FSM next state and outputs, all derived from the post-edge cnt/idx so
  // the registered outputs carry no extra latency.
  // Entering DRIVE happens either from BLANK, or at a slot wrap when there
  // is no blank phase (BLANK_CYCLES = 0 keeps the FSM in DRIVE throughout).
  // The signed int compare keeps BLANK_CYCLES = 0 from becoming a
  // degenerate unsigned comparison.
  always_comb begin
    w_cnt_int   = int'(w_cnt_nxt);
    w_state_nxt = (w_cnt_int >= BLANK_CYCLES) ? ST_DRIVE : ST_BLANK;
    w_enter     = (w_state_nxt == ST_DRIVE) &&
                  ((r_state == ST_BLANK) || w_slot_wrap);

    // On the entry edge the snapshot is still being written, so the
    // outputs take the fresh input directly.
    w_cur_seg = w_enter ? w_in_seg : r_snap_seg;
    w_cur_en  = w_enter ? w_in_en  : r_snap_en;

    w_seg_nxt = 7'h7F;
    w_an_nxt  = '1;
    if ((w_state_nxt == ST_DRIVE) && w_cur_en) begin
      w_seg_nxt = w_cur_seg;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_idx_nxt == IDX_W'(i)) begin
          w_an_nxt[i] = 1'b0;
        end
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= ST_BLANK;
      r_seg   <= 7'h7F;
      r_an    <= '1;
      r_frame <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_state <= w_state_nxt;
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  // Snapshot register: data only, its content is irrelevant during reset
  always_ff @(posedge clk) begin
    if (w_enter) begin
      r_snap_seg <= w_in_seg;
      r_snap_en  <= w_in_en;
    end
  end

  assign seg_out    = r_seg;
  assign an_out     = r_an;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame;

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic            clk;
  logic            rst;
  logic [ND*7-1:0] segments_in;
  logic [ND-1:0]   digit_en;
  logic [6:0]      seg_out;
  logic [ND-1:0]   an_out;
  logic [1:0]      digit_idx;
  logic            frame_done;

  int n_checks;
  int n_errors;

  // Reference model state: edges since reset release plus the slot snapshot
  int         m_e;
  logic [6:0] m_snap;
  logic       m_snap_en;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic [1:0] exp_idx;
  logic       exp_frame;

  display_scanner #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .segments_in(segments_in),
    .digit_en   (digit_en),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of one rising edge, from the timing rules expressed on the edge count
  task automatic model_edge();
    int cnt;
    int idx;
    if (rst) begin
      m_e       = 0;
      exp_seg   = 7'h7F;
      exp_an    = 4'hF;
      exp_idx   = 2'd0;
      exp_frame = 1'b0;
    end else begin
      m_e++;
      cnt = m_e % DIV;
      idx = (m_e / DIV) % ND;
      if (cnt == BLANK) begin
        m_snap    = segments_in[7*idx +: 7];
        m_snap_en = digit_en[idx];
      end
      exp_idx   = 2'(idx);
      exp_frame = (cnt == 0) && (idx == 0);
      if ((cnt < BLANK) || !m_snap_en) begin
        exp_seg = 7'h7F;
        exp_an  = 4'hF;
      end else begin
        exp_seg = m_snap;
        exp_an  = ~(4'b0001 << idx);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("seg_out",    32'(seg_out),    32'(exp_seg));
    chk("an_out",     32'(an_out),     32'(exp_an));
    chk("digit_idx",  32'(digit_idx),  32'(exp_idx));
    chk("frame_done", 32'(frame_done), 32'(exp_frame));
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    m_e         = 0;
    m_snap      = 7'h7F;
    m_snap_en   = 1'b0;
    rst         = 1'b1;
    digit_en    = 4'b1111;
    segments_in = 28'($urandom());
    segments_in[6:0]  = 7'h01;
    segments_in[13:7] = 7'h4F;

    // Reset held for three cycles
    repeat (3) tick();
    chk("rst_an",    32'(an_out),     32'h0000000F);
    chk("rst_seg",   32'(seg_out),    32'h0000007F);
    chk("rst_idx",   32'(digit_idx),  32'h0);
    chk("rst_frame", 32'(frame_done), 32'h0);

    // Directed scan: edges 1..100 after release
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (e == 1)  chk("e1_blank_an", 32'(an_out), 32'h0000000F);
      if (e == 2)  begin
        chk("e2_an",  32'(an_out),  32'h0000000E);
        chk("e2_seg", 32'(seg_out), 32'h00000001);
      end
      if (e == 4)  segments_in[6:0] = 7'h12;
      if (e == 7)  chk("e7_seg_hold", 32'(seg_out), 32'h00000001);
      if (e == 9)  begin
        chk("e9_blank_an", 32'(an_out),    32'h0000000F);
        chk("e9_idx",      32'(digit_idx), 32'h00000001);
      end
      if (e == 10) begin
        chk("e10_an",  32'(an_out),  32'h0000000D);
        chk("e10_seg", 32'(seg_out), 32'h0000004F);
      end
      if (e == 15) digit_en = 4'b1011;
      if (e == 20) begin
        chk("e20_dis_an",  32'(an_out),    32'h0000000F);
        chk("e20_dis_seg", 32'(seg_out),   32'h0000007F);
        chk("e20_idx",     32'(digit_idx), 32'h00000002);
      end
      if (e == 31) chk("e31_frame", 32'(frame_done), 32'h0);
      if (e == 32) chk("e32_frame", 32'(frame_done), 32'h1);
      if (e == 33) chk("e33_frame", 32'(frame_done), 32'h0);
      if (e == 33) chk("e33_seg_old", 32'(seg_out), 32'h0000007F);
      if (e == 34) chk("e34_seg_new", 32'(seg_out), 32'h00000012);
      if (e == 64) chk("e64_frame", 32'(frame_done), 32'h1);
      if (e == 96) chk("e96_frame", 32'(frame_done), 32'h1);
      if (e == 97) chk("e97_frame", 32'(frame_done), 32'h0);
    end

    // Reset in the middle of a slot: rst high on edge 13
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    segments_in[6:0] = 7'h01;
    digit_en = 4'b1111;
    for (int e = 1; e <= 12; e++) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_an",    32'(an_out),     32'h0000000F);
    chk("mid_rst_seg",   32'(seg_out),    32'h0000007F);
    chk("mid_rst_idx",   32'(digit_idx),  32'h0);
    chk("mid_rst_frame", 32'(frame_done), 32'h0);
    rst = 1'b0;
    tick();
    chk("restart_e1_an",  32'(an_out),    32'h0000000F);
    chk("restart_e1_idx", 32'(digit_idx), 32'h0);
    tick();
    chk("restart_e2_an",  32'(an_out),  32'h0000000E);
    chk("restart_e2_seg", 32'(seg_out), 32'h00000001);

    // Randomized operation with occasional resets
    for (int c = 0; c < 3000; c++) begin
      segments_in = 28'($urandom());
      if ($urandom_range(0, 3) == 0) digit_en = 4'($urandom());
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
